fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the RISC-V multicycle core. Owns the PC, the instruction register and the fetch FSM that the first-generation top level spread across its PC register, the +4 ALU, the instruction register and the control state machine.
- Adds the following over that first generation:
  - configurable memory read latency;
  - a valid/ready handshake towards decode;
  - stall;
  - branch/jump redirect with abort of an in-flight fetch;
  - misaligned-target fault.
- Sits between the instruction memory and the decode/control unit.

Parameters:
- XLEN, 64: PC and address width.
- ILEN, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset. Must be 4-byte aligned.
- MEM_LATENCY, 1: cycles from the request cycle to the cycle in which imem_rdata is valid. Legal range is 1 to 15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous reset, active-high.
- imem_addr  out  XLEN  instruction memory read address (current PC).
- imem_rd  out  1  read strobe, high only in the REQ state.
- imem_rdata  in  ILEN  read data, valid MEM_LATENCY cycles after the request cycle.
- stall  in  1  blocks issue of new requests.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  XLEN  redirect target.
- instr  out  ILEN  instruction register contents.
- instr_pc  out  XLEN  PC of the instruction held in instr.
- instr_valid  out  1  instr/instr_pc valid for decode.
- instr_ready  in  1  decode accepts instr.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- misalign_fault  out  1  sticky fault flag.

Behaviour:
- Reset values (asynchronous, while RST=1):
  - pc = RESET_PC; state = BOOT; wait counter = 0.
  - instr = 0; instr_pc = 0; instr_valid = 0; imem_rd = 0; misalign_fault = 0.
  - imem_addr reflects pc.
- Field outputs (opcode, rd, rs1, rs2) are pure slices of instr.
- FSM states: BOOT, REQ, WAIT, HOLD, FAULT.
  - BOOT: one cycle after reset release, then REQ unconditionally. Redirect is ignored in BOOT.
  - REQ:
    - If stall=1: imem_rd=0 and the FSM stays in REQ.
    - Otherwise: imem_rd=1, imem_addr=pc, counter loaded with MEM_LATENCY, go to WAIT.
  - WAIT:
    - Counter decrements each cycle.
    - In the cycle where the counter equals 1: capture instr <= imem_rdata and instr_pc <= pc, then pc <= pc+4 (modulo 2^XLEN, wraps to 0) and go to HOLD.
    - WAIT therefore lasts exactly MEM_LATENCY cycles.
  - HOLD:
    - instr_valid=1.
    - When instr_ready=1, the handshake completes that cycle; next state is REQ and instr_valid=0 from the next cycle.
    - instr and instr_pc keep their value until the next capture.
    - stall does not block acceptance.
  - FAULT: instr_valid=0, imem_rd=0. Only RST exits.
- Best-case throughput: one instruction per MEM_LATENCY+2 cycles (REQ, WAIT×MEM_LATENCY, HOLD with ready=1).
- Redirect (states REQ, WAIT, HOLD) has priority over every other transition in the same cycle:
  - Aligned target (redirect_pc[1:0]==0):
    - pc <= redirect_pc; instr_valid=0 from the next cycle; next state REQ.
    - An in-flight read in WAIT is abandoned; its data is never captured.
    - A HOLD instruction is dropped even if instr_ready=1 in the same cycle. Decode must not consume it.
  - Misaligned target (redirect_pc[1:0]!=0): misalign_fault <= 1, pc unchanged, next state FAULT.
- Simultaneous redirect and stall: the redirect takes effect; stall then applies in REQ.
- imem_rdata is sampled only in the capture cycle; other values are ignored.
- RST asserted mid-fetch returns all state to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset then run, with MEM_LATENCY=1, instr_ready=1, memory words 0x00500093 at address 0 and 0x00A00113 at address 4:
  - imem_rd pulses at cycles 1 and 4;
  - instr_valid at cycles 3 and 6;
  - instr_pc = 0 then 4;
  - for the first word, opcode=0x13, rd=1, rs1=0, rs2=5.
- MEM_LATENCY=3, instr_ready held 0 for 5 cycles:
  - instr_valid stays 1 with a stable instr;
  - no new imem_rd until one cycle after ready rises;
  - pc=4 throughout the hold.
- Redirect to 0x100 during WAIT:
  - the old data is never captured;
  - the next imem_rd has imem_addr=0x100;
  - the next valid instruction has instr_pc=0x100.
- Redirect to 0x102 in HOLD with instr_ready=1 in the same cycle:
  - misalign_fault=1 and instr_valid=0 from the next cycle;
  - no further imem_rd until RST, after which pc=RESET_PC and the fault is cleared.
- stall=1 for 4 cycles in REQ: imem_rd=0 during the stall; a request with unchanged imem_addr is issued in the cycle stall drops.
- Wrap-around with RESET_PC=0xFFFFFFFFFFFFFFFC: the first instr_pc=0xFFFFFFFFFFFFFFFC, and the next request has imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction register and fetch FSM (BOOT/REQ/WAIT/HOLD/FAULT) with read latency, decode handshake, stall, redirect and misaligned-target fault
module fetch_unit #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int MEM_LATENCY = 1
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            misalign_fault
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, FAULT} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] pc;
  logic [3:0] cnt;
  logic redir, bad, cap;
  assign redir = redirect_valid && (state == REQ || state == WAIT || state == HOLD);
  assign bad = redirect_pc[1:0] != 2'b00;
  assign cap = state == WAIT && cnt == 4'd1 && !redir;
  assign imem_rd = state == REQ && !stall;
  assign imem_addr = pc;
  assign instr_valid = state == HOLD;
  assign opcode = instr[6:0];
  assign rd = instr[11:7];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  always_comb begin
    state_n = state;
    case (state)
      BOOT:    state_n = REQ;
      REQ:     state_n = stall ? REQ : WAIT;
      WAIT:    state_n = cnt == 4'd1 ? HOLD : WAIT;
      HOLD:    state_n = instr_ready ? REQ : HOLD;
      default: state_n = state;
    endcase
    if (redir) state_n = bad ? FAULT : REQ;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= BOOT;
      pc <= RESET_PC;
      cnt <= '0;
      instr <= '0;
      instr_pc <= '0;
      misalign_fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= imem_rd ? 4'(MEM_LATENCY) : state == WAIT ? cnt - 4'd1 : cnt;
      pc <= redir && !bad ? redirect_pc : cap ? pc + XLEN'(4) : pc;
      if (cap) begin
        instr <= imem_rdata;
        instr_pc <= pc;
      end
      if (redir && bad) misalign_fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: two fetch_unit instances (latency 1 at PC 0, latency 3 at the top of the address space) against a behavioural model
module tb_fetch_unit;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic stall = 1'b0;
  logic rv = 1'b0;
  logic ready = 1'b1;
  logic [63:0] rpc = '0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always #5 CLK = ~CLK;
  function automatic logic [31:0] mem(input logic [63:0] a);
    return a == 64'd0 ? 32'h00500093 : a == 64'd4 ? 32'h00A00113 : (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0013;
  endfunction
  task automatic chk(input int k, input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL u%0d %s at t=%0t: got %h expected %h", k, n, $time, a, e);
    end
  endtask
  for (genvar k = 0; k < 2; k++) begin : g
    localparam int LAT = k == 0 ? 1 : 3;
    localparam logic [63:0] RPC = k == 0 ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFC;
    logic [63:0] imem_addr, instr_pc, raddr;
    logic [31:0] imem_rdata, instr;
    logic imem_rd, instr_valid, misalign_fault;
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    int since = 0;
    bit m_boot, m_fault, m_hold, idle;
    int m_wait;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(RPC), .MEM_LATENCY(LAT)) dut (
      .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
      .stall(stall), .redirect_valid(rv), .redirect_pc(rpc), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(ready), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .misalign_fault(misalign_fault)
    );
    always @(posedge CLK) begin
      if (imem_rd) begin
        raddr <= imem_addr;
        since <= 1;
      end else since <= since + 1;
    end
    assign imem_rdata = since == LAT ? mem(raddr) : ~mem(raddr);
    always @(negedge CLK) begin
      if (RST) begin
        m_boot = 1; m_fault = 0; m_hold = 0; m_wait = 0;
        m_pc = RPC; m_ipc = '0; m_instr = '0;
      end
      idle = !m_boot && !m_fault && !m_hold && m_wait == 0;
      chk(k, "imem_rd", imem_rd, idle && !stall);
      chk(k, "imem_addr", imem_addr, m_pc);
      chk(k, "instr_valid", instr_valid, m_hold);
      chk(k, "instr", instr, m_instr);
      chk(k, "instr_pc", instr_pc, m_ipc);
      chk(k, "opcode", opcode, m_instr[6:0]);
      chk(k, "rd", rd, m_instr[11:7]);
      chk(k, "rs1", rs1, m_instr[19:15]);
      chk(k, "rs2", rs2, m_instr[24:20]);
      chk(k, "fault", misalign_fault, m_fault);
      if (!RST) begin
        if (m_boot) m_boot = 0;
        else if (!m_fault) begin
          if (rv) begin
            if (rpc[1:0] != 2'b00) m_fault = 1;
            else m_pc = rpc;
            m_wait = 0;
            m_hold = 0;
          end else if (m_hold) m_hold = !ready;
          else if (m_wait == 1) begin
            m_instr = mem(m_pc);
            m_ipc = m_pc;
            m_pc = m_pc + 64'd4;
            m_hold = 1;
            m_wait = 0;
          end else if (m_wait > 1) m_wait--;
          else if (!stall) m_wait = LAT;
        end
      end
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    RST = 1'b1; stall = 1'b0; rv = 1'b0; ready = 1'b1; rpc = '0;
    tick();
    RST = 1'b0;
    cyc = 0;
  endtask
  initial begin
    #1 RST = 1'b1;
    tick();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      @(negedge CLK);
      chk(0, "A.rd", g[0].imem_rd, c == 1 || c == 4);
      chk(0, "A.valid", g[0].instr_valid, c == 3 || c == 6);
      if (c == 3) begin
        chk(0, "A.pc0", g[0].instr_pc, 64'd0);
        chk(0, "A.opcode", g[0].opcode, 7'h13);
        chk(0, "A.rd_f", g[0].rd, 5'd1);
        chk(0, "A.rs1", g[0].rs1, 5'd0);
        chk(0, "A.rs2", g[0].rs2, 5'd5);
      end
      if (c == 6) begin
        chk(0, "A.pc1", g[0].instr_pc, 64'd4);
        chk(0, "A.instr1", g[0].instr, 32'h00A00113);
        chk(1, "A.wrap_rd", g[1].imem_rd, 1'b1);
        chk(1, "A.wrap_addr", g[1].imem_addr, 64'd0);
      end
      if (c == 5) chk(1, "A.wrap_pc", g[1].instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
    end
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      ready = c >= 10;
      @(negedge CLK);
      if (c >= 5 && c <= 10) begin
        chk(1, "B.valid", g[1].instr_valid, 1'b1);
        chk(1, "B.instr", g[1].instr, mem(64'hFFFF_FFFF_FFFF_FFFC));
        chk(1, "B.rd", g[1].imem_rd, 1'b0);
        chk(1, "B.pc", g[1].imem_addr, 64'd0);
      end
      if (c == 11) chk(1, "B.req", g[1].imem_rd, 1'b1);
      tick();
    end
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      rv = c == 3;
      rpc = 64'h100;
      @(negedge CLK);
      if (c == 4) begin
        chk(1, "C.rd", g[1].imem_rd, 1'b1);
        chk(1, "C.addr", g[1].imem_addr, 64'h100);
      end
      if (c == 7) chk(1, "C.no_capture", g[1].instr_pc, 64'd0);
      if (c == 8) begin
        chk(1, "C.valid", g[1].instr_valid, 1'b1);
        chk(1, "C.pc", g[1].instr_pc, 64'h100);
        chk(1, "C.instr", g[1].instr, mem(64'h100));
      end
      tick();
    end
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      rv = c == 5;
      rpc = 64'h102;
      @(negedge CLK);
      if (c == 5) chk(1, "D.valid_before", g[1].instr_valid, 1'b1);
      if (c >= 6) begin
        chk(1, "D.fault", g[1].misalign_fault, 1'b1);
        chk(1, "D.valid", g[1].instr_valid, 1'b0);
        chk(1, "D.rd", g[1].imem_rd, 1'b0);
      end
      tick();
    end
    do_reset();
    @(negedge CLK);
    chk(1, "D.fault_clr", g[1].misalign_fault, 1'b0);
    chk(1, "D.pc_reset", g[1].imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      stall = c >= 1 && c <= 4;
      @(negedge CLK);
      if (c >= 1) begin
        chk(0, "E.rd", g[0].imem_rd, c == 5);
        chk(0, "E.addr", g[0].imem_addr, 64'd0);
        chk(1, "E.rd", g[1].imem_rd, c == 5);
        chk(1, "E.addr", g[1].imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      end
      tick();
    end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      RST = $urandom_range(99) == 0;
      stall = $urandom_range(3) == 0;
      ready = $urandom_range(1) == 1;
      rv = $urandom_range(19) == 0;
      rpc = {$urandom, $urandom};
      if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      if ($urandom_range(7) != 0) rpc[1:0] = 2'b00;
      tick();
    end
    RST = 1'b0;
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
